axi_w_route_ctrl: RTL and testbench

- Sequences the shared AXI W channel among the write-capable cache-subsystem masters (I$, bypass, D$ ports).
- Records which source won each AW handshake and how many beats it owes, in issue order.
- Routes exactly that many W beats from that source, then advances to the next source.
- Drives AW back-pressure when the order queue is full, checks WLAST against the granted burst length, and reports busy while any write data is owed.

---
 rtl/axi_w_route_ctrl.sv | 158 +++++++++++++++
 tb/tb_axi_w_route_ctrl.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_w_route_ctrl.sv
// axi_w_route_ctrl: orders the shared AXI W channel among write sources.
// Each accepted AW pushes {src, len} into an order queue. The head entry
// selects which source drives W, and a beat counter generates WLAST and
// pops the head after len+1 beats. A source's own WLAST is only compared
// against the counter and sets a sticky protocol-error flag on disagreement.
// Optional build macro: AXI_W_ROUTE_FALLTHROUGH_EN lets an AW arriving at an
// empty queue drive the W routing in the same cycle.
module axi_w_route_ctrl #(
    parameter int unsigned NumSrc = 3,
    parameter int unsigned Depth  = 4,
    parameter int unsigned LenW   = 8,
    localparam int unsigned SrcW  = (NumSrc > 1) ? $clog2(NumSrc) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              aw_valid_i,
    input  logic              aw_ready_i,
    input  logic [SrcW-1:0]   aw_src_i,
    input  logic [LenW-1:0]   aw_len_i,
    output logic              aw_stall_o,
    input  logic [NumSrc-1:0] src_w_valid_i,
    input  logic [NumSrc-1:0] src_w_last_i,
    output logic [NumSrc-1:0] src_w_ready_o,
    output logic [SrcW-1:0]   w_sel_o,
    output logic              w_valid_o,
    output logic              w_last_o,
    input  logic              w_ready_i,
    output logic              busy_o,
    output logic              proto_err_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    // Order queue storage; data needs no reset since r_count gates every read.
    logic [SrcW-1:0] r_src_mem [Depth];
    logic [LenW-1:0] r_len_mem [Depth];

    logic [PtrW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic [LenW-1:0] r_bcnt;
    logic            r_proto_err;

    logic [PtrW-1:0] w_wr_ptr_d, w_rd_ptr_d;
    logic [CntW-1:0] w_count_d;
    logic [LenW-1:0] w_bcnt_d;
    logic            w_proto_err_d;

    logic            w_full, w_empty;
    logic            w_push, w_store, w_beat, w_pop, w_mem_pop;
    logic            w_head_vld;
    logic [SrcW-1:0] w_head_src;
    logic [LenW-1:0] w_head_len;
    logic            w_src_last;

    assign w_full     = (r_count == CntW'(Depth));
    assign w_empty    = (r_count == '0);
    assign aw_stall_o = w_full;
    assign busy_o     = ~w_empty;
    assign proto_err_o = r_proto_err;

    // Stall is registered-only, so the push qualifier never sees the W side.
    assign w_push = aw_valid_i & aw_ready_i & ~w_full;

    // Select the entry currently owning the W channel.
    always_comb begin
        w_head_vld = ~w_empty;
        w_head_src = r_src_mem[r_rd_ptr];
        w_head_len = r_len_mem[r_rd_ptr];
`ifdef AXI_W_ROUTE_FALLTHROUGH_EN
        if (w_empty && w_push) begin
            w_head_vld = 1'b1;
            w_head_src = aw_src_i;
            w_head_len = aw_len_i;
        end
`endif
    end

    // Route the head source onto the downstream W channel.
    always_comb begin
        w_sel_o       = '0;
        w_valid_o     = 1'b0;
        w_last_o      = 1'b0;
        src_w_ready_o = '0;
        w_src_last    = 1'b0;
        if (w_head_vld) begin
            w_sel_o  = w_head_src;
            w_last_o = (r_bcnt == w_head_len);
            for (int unsigned i = 0; i < NumSrc; i++) begin
                if (w_head_src == SrcW'(i)) begin
                    w_valid_o        = src_w_valid_i[i];
                    src_w_ready_o[i] = w_ready_i;
                    w_src_last       = src_w_last_i[i];
                end
            end
        end
    end

    assign w_beat = w_valid_o & w_ready_i;
    assign w_pop  = w_beat & w_last_o;
    // A fall-through entry finished in its own AW cycle is never stored.
    assign w_store   = w_push & ~(w_empty & w_pop);
    assign w_mem_pop = w_pop & ~w_empty;

    // Next-state for pointers, occupancy, beat counter and error flag.
    always_comb begin
        w_wr_ptr_d    = r_wr_ptr;
        w_rd_ptr_d    = r_rd_ptr;
        w_count_d     = r_count;
        w_bcnt_d      = r_bcnt;
        w_proto_err_d = r_proto_err;

        if (w_store) begin
            w_wr_ptr_d = r_wr_ptr + PtrW'(1);
        end
        if (w_mem_pop) begin
            w_rd_ptr_d = r_rd_ptr + PtrW'(1);
        end
        if (w_store && !w_mem_pop) begin
            w_count_d = r_count + CntW'(1);
        end else if (!w_store && w_mem_pop) begin
            w_count_d = r_count - CntW'(1);
        end

        if (w_beat) begin
            w_bcnt_d = w_last_o ? '0 : r_bcnt + LenW'(1);
            if (w_src_last != w_last_o) begin
                w_proto_err_d = 1'b1;
            end
        end
    end

    // Control state with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_bcnt      <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_d;
            r_rd_ptr    <= w_rd_ptr_d;
            r_count     <= w_count_d;
            r_bcnt      <= w_bcnt_d;
            r_proto_err <= w_proto_err_d;
        end
    end

    // Queue payload write.
    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_src_mem[r_wr_ptr] <= aw_src_i;
            r_len_mem[r_wr_ptr] <= aw_len_i;
        end
    end

endmodule

// File: tb/tb_axi_w_route_ctrl.sv
// Bench for axi_w_route_ctrl: directed scenarios plus randomized traffic
// checked against a queue-of-transactions reference model.
module tb_axi_w_route_ctrl;

    localparam int NUM_SRC = 3;
    localparam int DEPTH   = 4;
    localparam int LEN_W   = 8;
    localparam int SRC_W   = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               aw_valid = 1'b0, aw_ready = 1'b0;
    logic [SRC_W-1:0]   aw_src = '0;
    logic [LEN_W-1:0]   aw_len = '0;
    logic               aw_stall_o;
    logic [NUM_SRC-1:0] src_w_valid = '0, src_w_last = '0;
    logic [NUM_SRC-1:0] src_w_ready_o;
    logic [SRC_W-1:0]   w_sel_o;
    logic               w_valid_o, w_last_o;
    logic               w_ready = 1'b0;
    logic               busy_o, proto_err_o;

    always #5 clk = ~clk;

    axi_w_route_ctrl #(
        .NumSrc(NUM_SRC),
        .Depth (DEPTH),
        .LenW  (LEN_W)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .aw_valid_i   (aw_valid),
        .aw_ready_i   (aw_ready),
        .aw_src_i     (aw_src),
        .aw_len_i     (aw_len),
        .aw_stall_o   (aw_stall_o),
        .src_w_valid_i(src_w_valid),
        .src_w_last_i (src_w_last),
        .src_w_ready_o(src_w_ready_o),
        .w_sel_o      (w_sel_o),
        .w_valid_o    (w_valid_o),
        .w_last_o     (w_last_o),
        .w_ready_i    (w_ready),
        .busy_o       (busy_o),
        .proto_err_o  (proto_err_o)
    );

    typedef struct {
        int src;
        int len;
    } ent_t;

    ent_t mq[$];      // transactions accepted on AW, W not finished
    int   m_done;     // beats already sent for the head transaction
    bit   m_err;

    int n_tests = 0;
    int n_fail  = 0;

    bit               e_valid, e_last, e_busy, e_stall, e_err;
    logic [SRC_W-1:0] e_sel;
    logic [2:0]       e_ready;

    task automatic model_head(output bit hv, output int hs, output int hl);
        hv = 1'b0; hs = 0; hl = 0;
        if (mq.size() > 0) begin
            hv = 1'b1; hs = mq[0].src; hl = mq[0].len;
        end
`ifdef AXI_W_ROUTE_FALLTHROUGH_EN
        else if (aw_valid && aw_ready) begin
            hv = 1'b1; hs = int'(aw_src); hl = int'(aw_len);
        end
`endif
    endtask

    task automatic model_expect();
        bit hv;
        int hs, hl;
        model_head(hv, hs, hl);
        e_busy  = (mq.size() > 0);
        e_stall = (mq.size() == DEPTH);
        e_err   = m_err;
        e_sel   = hv ? hs[SRC_W-1:0] : '0;
        e_valid = hv && src_w_valid[hs];
        e_last  = hv && (m_done == hl);
        e_ready = '0;
        if (hv) e_ready[hs] = w_ready;
    endtask

    task automatic model_commit();
        bit   hv, push, beat;
        int   hs, hl;
        ent_t e;
        push = aw_valid && aw_ready && (mq.size() < DEPTH);
        model_head(hv, hs, hl);
        beat = hv && src_w_valid[hs] && w_ready;
        if (push) begin
            e.src = int'(aw_src);
            e.len = int'(aw_len);
            mq.push_back(e);
        end
        if (beat) begin
            if (src_w_last[hs] != (m_done == hl)) m_err = 1'b1;
            if (m_done == hl) begin
                void'(mq.pop_front());
                m_done = 0;
            end else begin
                m_done++;
            end
        end
    endtask

    task automatic cycle();
        model_commit();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        aw_valid = 1'b0; aw_ready = 1'b0; aw_src = '0; aw_len = '0;
        src_w_valid = '0; src_w_last = '0; w_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete();
        m_done = 0;
        m_err  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #3;
        n_tests++;
        if ({aw_stall_o, busy_o, proto_err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_status: stall/busy/err=%b expected 000",
                     {aw_stall_o, busy_o, proto_err_o});
        end
        n_tests++;
        if ({w_sel_o, w_valid_o, w_last_o, src_w_ready_o} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_route: sel=%0d valid=%b last=%b ready=%b expected all 0",
                     w_sel_o, w_valid_o, w_last_o, src_w_ready_o);
        end
        cycle();
    endtask

    task automatic test_single_burst();
        do_reset();
        aw_valid = 1'b1; aw_ready = 1'b1; aw_src = 2'd2; aw_len = 8'd3;
        #3;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_aw_cycle_busy: got %b expected 0", busy_o);
        end
        cycle();
        aw_valid = 1'b0;
        src_w_valid = 3'b100; w_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            src_w_last = (b == 3) ? 3'b100 : 3'b000;
            #3;
            n_tests++;
            if ({w_sel_o, w_valid_o, w_last_o, src_w_ready_o, busy_o} !==
                {2'd2, 1'b1, (b == 3), 3'b100, 1'b1}) begin
                n_fail++;
                $display("FAIL burst_beat%0d: sel=%0d valid=%b last=%b ready=%b busy=%b expected sel=2 valid=1 last=%b ready=100 busy=1",
                         b, w_sel_o, w_valid_o, w_last_o, src_w_ready_o, busy_o, (b == 3));
            end
            cycle();
        end
        src_w_valid = '0; src_w_last = '0;
        #3;
        n_tests++;
        if ({busy_o, w_valid_o, proto_err_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL burst_done: busy/valid/err=%b expected 000",
                     {busy_o, w_valid_o, proto_err_o});
        end
        cycle();
    endtask

    task automatic test_fill_stall();
        int srcs[4] = '{1, 2, 1, 2};
        int lens[4] = '{0, 1, 0, 0};
        int exp_seq[7] = '{1, 2, 2, 1, 2, 0, 0};
        int seq[$];
        int accept_at;
        bit accepted;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            aw_valid = 1'b1; aw_ready = 1'b1;
            aw_src = srcs[k][SRC_W-1:0]; aw_len = lens[k][LEN_W-1:0];
            cycle();
        end
        aw_src = 2'd0; aw_len = 8'd1;
        #3;
        n_tests++;
        if (aw_stall_o !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_stall: got %b expected 1", aw_stall_o);
        end
        cycle();
        accepted = 1'b0;
        accept_at = -1;
        src_w_valid = 3'b111; w_ready = 1'b1;
        for (int c = 0; c < 40 && seq.size() < 7; c++) begin
            model_expect();
            src_w_last = {3{e_last}};
            #3;
            if (!accepted && aw_valid && !aw_stall_o) begin
                accepted = 1'b1;
                accept_at = seq.size();
            end
            if (w_valid_o && w_ready) seq.push_back(int'(w_sel_o));
            cycle();
            if (accepted) aw_valid = 1'b0;
        end
        n_tests++;
        if (accept_at != 1) begin
            n_fail++;
            $display("FAIL fill_fifth_aw: accepted after %0d beats expected 1", accept_at);
        end
        n_tests++;
        if (seq.size() != 7) begin
            n_fail++;
            $display("FAIL fill_beat_count: got %0d expected 7", seq.size());
        end else begin
            for (int i = 0; i < 7; i++) begin
                if (seq[i] != exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL fill_order beat %0d: src %0d expected %0d",
                             i, seq[i], exp_seq[i]);
                    break;
                end
            end
        end
        clear_inputs();
        #3;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_drained: busy=%b expected 0", busy_o);
        end
        cycle();
    endtask

    task automatic test_random();
        int errs = 0;
        bit saw_full = 1'b0;
        do_reset();
        for (int c = 0; c < 500; c++) begin
            aw_valid    = ($urandom_range(0, 3) != 0);
            aw_ready    = ($urandom_range(0, 3) != 0);
            aw_src      = 2'($urandom_range(0, 2));
            aw_len      = 8'($urandom_range(0, 3));
            src_w_valid = 3'($urandom);
            w_ready     = ($urandom_range(0, 2) != 0);
            model_expect();
            src_w_last  = {3{e_last}};
            #3;
            if (aw_stall_o === 1'b1) saw_full = 1'b1;
            n_tests++;
            if ({w_sel_o, w_valid_o, w_last_o, src_w_ready_o, busy_o, aw_stall_o, proto_err_o} !==
                {e_sel, e_valid, e_last, e_ready, e_busy, e_stall, e_err}) begin
                n_fail++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc %0d: sel=%0d v=%b l=%b rdy=%b busy=%b stall=%b err=%b expected sel=%0d v=%b l=%b rdy=%b busy=%b stall=%b err=%b",
                             c, w_sel_o, w_valid_o, w_last_o, src_w_ready_o, busy_o, aw_stall_o,
                             proto_err_o, e_sel, e_valid, e_last, e_ready, e_busy, e_stall, e_err);
            end
            cycle();
        end
        n_tests++;
        if (!saw_full) begin
            n_fail++;
            $display("FAIL random_full_reached: aw_stall_o never 1, expected it to assert");
        end
        clear_inputs();
    endtask

    task automatic test_proto_err();
        do_reset();
        aw_valid = 1'b1; aw_ready = 1'b1; aw_src = 2'd2; aw_len = 8'd3;
        cycle();
        aw_valid = 1'b0;
        src_w_valid = 3'b100; w_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            src_w_last = (b == 1 || b == 3) ? 3'b100 : 3'b000;
            #3;
            n_tests++;
            if ({proto_err_o, w_valid_o, w_last_o} !== {(b >= 2), 1'b1, (b == 3)}) begin
                n_fail++;
                $display("FAIL proto_beat%0d: err=%b valid=%b last=%b expected err=%b valid=1 last=%b",
                         b, proto_err_o, w_valid_o, w_last_o, (b >= 2), (b == 3));
            end
            cycle();
        end
        clear_inputs();
        repeat (2) cycle();
        #3;
        n_tests++;
        if ({proto_err_o, busy_o} !== 2'b10) begin
            n_fail++;
            $display("FAIL proto_sticky: err/busy=%b expected 10", {proto_err_o, busy_o});
        end
        do_reset();
        #3;
        n_tests++;
        if (proto_err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL proto_cleared: got %b expected 0", proto_err_o);
        end
        cycle();
    endtask

    task automatic test_async_reset();
        do_reset();
        aw_valid = 1'b1; aw_ready = 1'b1; aw_src = 2'd1; aw_len = 8'd3;
        cycle();
        aw_valid = 1'b0;
        src_w_valid = 3'b010; w_ready = 1'b1;
        repeat (2) cycle();
        // Two beats done; assert reset away from any clock edge.
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({w_sel_o, w_valid_o, w_last_o, src_w_ready_o, busy_o, aw_stall_o} !== 9'd0) begin
            n_fail++;
            $display("FAIL async_reset: sel=%0d valid=%b last=%b ready=%b busy=%b stall=%b expected all 0",
                     w_sel_o, w_valid_o, w_last_o, src_w_ready_o, busy_o, aw_stall_o);
        end
        do_reset();
        aw_valid = 1'b1; aw_ready = 1'b1; aw_src = 2'd0; aw_len = 8'd0;
        cycle();
        aw_valid = 1'b0;
        src_w_valid = 3'b001; src_w_last = 3'b001; w_ready = 1'b1;
        #3;
        n_tests++;
        if ({w_sel_o, w_valid_o, w_last_o, src_w_ready_o} !== {2'd0, 1'b1, 1'b1, 3'b001}) begin
            n_fail++;
            $display("FAIL post_reset_route: sel=%0d valid=%b last=%b ready=%b expected sel=0 valid=1 last=1 ready=001",
                     w_sel_o, w_valid_o, w_last_o, src_w_ready_o);
        end
        cycle();
        clear_inputs();
        #3;
        n_tests++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_done: busy=%b expected 0", busy_o);
        end
        cycle();
    endtask

`ifdef AXI_W_ROUTE_FALLTHROUGH_EN
    task automatic test_fallthrough();
        do_reset();
        aw_valid = 1'b1; aw_ready = 1'b1; aw_src = 2'd1; aw_len = 8'd0;
        src_w_valid = 3'b010; src_w_last = 3'b010; w_ready = 1'b1;
        #3;
        n_tests++;
        if ({w_sel_o, w_valid_o, w_last_o, src_w_ready_o} !== {2'd1, 1'b1, 1'b1, 3'b010}) begin
            n_fail++;
            $display("FAIL fallthrough_route: sel=%0d valid=%b last=%b ready=%b expected sel=1 valid=1 last=1 ready=010",
                     w_sel_o, w_valid_o, w_last_o, src_w_ready_o);
        end
        cycle();
        clear_inputs();
        #3;
        n_tests++;
        if ({busy_o, proto_err_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL fallthrough_busy: busy/err=%b expected 00", {busy_o, proto_err_o});
        end
        cycle();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_burst();
        test_fill_stall();
        test_random();
        test_proto_err();
        test_async_reset();
`ifdef AXI_W_ROUTE_FALLTHROUGH_EN
        test_fallthrough();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
